// File: rtl/fp16_pkg.sv
// Shared binary16 field layout, constants and operand classification
// for the half-precision multiplier.
package fp16_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int BIAS   = 15;

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp16_t;

  typedef enum logic [2:0] {ZERO, SUBNORMAL, NORMAL, INF, NAN} fp_class_e;

  function automatic fp_class_e classify(input fp16_t x);
    if (x.exp == '1)
      return (x.frac != '0) ? NAN : INF;
    else if (x.exp == '0)
      return (x.frac != '0) ? SUBNORMAL : ZERO;
    else
      return NORMAL;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// 11-bit leading-zero counter used to normalize subnormal significands.
// Only compiled in when FPMUL_SUBNORMAL_EN is defined.
`ifdef FPMUL_SUBNORMAL_EN
module fp_lzc (
  input  logic [10:0] x,
  output logic [3:0]  cnt
);

  // Ascending scan: the most significant set bit is the last to write cnt.
  always_comb begin
    cnt = 4'd11;
    for (int i = 0; i <= 10; i++) begin
      if (x[i]) cnt = 4'(10 - i);
    end
  end

endmodule
`endif

// File: rtl/floating_point_multiplier.sv
// Registered binary16 multiplier with round-to-nearest-even.
// Define FPMUL_SUBNORMAL_EN for gradual underflow; otherwise subnormals flush to zero.
module floating_point_multiplier
  import fp16_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result
);

  if (DATA_WIDTH != 16) begin : g_width_check
    $error("floating_point_multiplier: DATA_WIDTH must be 16");
  end

  localparam bit SUB_EN =
`ifdef FPMUL_SUBNORMAL_EN
    1'b1;
`else
    1'b0;
`endif

  fp16_t            fa, fb;
  fp_class_e        ca, cb;
  logic             za, zb;
  logic [10:0]      ma, mb, man_a, man_b;
  logic [4:0]       ea_eff, eb_eff;
  logic [3:0]       lz_a, lz_b;
  logic signed [7:0] exp_a, exp_b;
  logic [15:0]      prod_p0;

  assign fa = a;
  assign fb = b;
  assign ca = classify(fa);
  assign cb = classify(fb);
  assign za = (ca == ZERO) || (!SUB_EN && ca == SUBNORMAL);
  assign zb = (cb == ZERO) || (!SUB_EN && cb == SUBNORMAL);

  // Subnormals carry implicit bit 0 with exponent 1.
  assign ma     = {|fa.exp, fa.frac};
  assign mb     = {|fb.exp, fb.frac};
  assign ea_eff = (fa.exp == 5'd0) ? 5'd1 : fa.exp;
  assign eb_eff = (fb.exp == 5'd0) ? 5'd1 : fb.exp;

`ifdef FPMUL_SUBNORMAL_EN
  fp_lzc u_lzc_a (.x(ma), .cnt(lz_a));
  fp_lzc u_lzc_b (.x(mb), .cnt(lz_b));
`else
  assign lz_a = 4'd0;
  assign lz_b = 4'd0;
`endif

  assign man_a = ma << lz_a;
  assign man_b = mb << lz_b;
  assign exp_a = signed'({3'b000, ea_eff}) - signed'({4'b0000, lz_a});
  assign exp_b = signed'({3'b000, eb_eff}) - signed'({4'b0000, lz_b});

  // The {exp, frac} concatenation lets a rounding carry ripple into the exponent.
  function automatic logic [15:0] round_pack(input logic s, input logic signed [7:0] ex,
                                             input logic [9:0] fr, input logic g,
                                             input logic st);
    logic signed [17:0] rv;
    logic signed [7:0]  er;
    rv = signed'({ex, fr}) + signed'({17'd0, g & (st | fr[0])});
    er = rv[17:10];
    if (er >= 8'sd31)
      return {s, POS_INF[14:0]};
    else if (er < 8'sd0 || (!SUB_EN && er == 8'sd0))
      return {s, 15'd0};
    else
      return {s, er[4:0], rv[9:0]};
  endfunction

  logic              sign;
  logic [21:0]       p, full;
  logic [20:0]       sig, shifted;
  logic signed [7:0] e, ebase;
  logic [7:0]        sh;
  logic [9:0]        frac;
  logic              g, st, lost;

  always_comb begin
    sign    = fa.sign ^ fb.sign;
    p       = 22'(man_a) * 22'(man_b);
    sig     = p[21] ? p[20:0] : {p[19:0], 1'b0};
    e       = exp_a + exp_b - 8'sd15 + (p[21] ? 8'sd1 : 8'sd0);
    full    = {1'b1, sig};
    sh      = 8'd0;
    shifted = '0;
    lost    = 1'b0;
    frac    = sig[20:11];
    g       = sig[10];
    st      = |sig[9:0];
    ebase   = e;
    if (SUB_EN && e <= 8'sd0) begin
      // Denormalize: shift the full significand right, folding lost bits into sticky.
      sh = 8'sd1 - e;
      if (sh > 8'd21) begin
        shifted = '0;
        lost    = |full;
      end else begin
        shifted = 21'(full >> sh);
        lost    = |(full & ~(22'h3FFFFF << sh));
      end
      frac  = shifted[20:11];
      g     = shifted[10];
      st    = (|shifted[9:0]) | lost;
      ebase = 8'sd0;
    end
    prod_p0 = round_pack(sign, ebase, frac, g, st);
    if (ca == NAN || cb == NAN || (ca == INF && zb) || (cb == INF && za))
      prod_p0 = QNAN;
    else if (ca == INF || cb == INF)
      prod_p0 = {sign, POS_INF[14:0]};
    else if (za || zb)
      prod_p0 = {sign, 15'd0};
  end

  // ---- output register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      result <= '0;
    else if (en)
      result <= prod_p0;
  end

endmodule

// File: tb/tb_floating_point_multiplier.sv
// Directed-vector bench for floating_point_multiplier (honours FPMUL_SUBNORMAL_EN).
module tb_floating_point_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] a, b;
  logic [15:0] result;

  int total  = 0;
  int passed = 0;

  floating_point_multiplier #(.DATA_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .a     (a),
    .b     (b),
    .result(result)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    vecs[0]  = '{16'h3C00, 16'h3C00, 16'h3C00};
    vecs[1]  = '{16'h3C01, 16'h3C01, 16'h3C02};
    vecs[2]  = '{16'h4200, 16'hC600, 16'hCC80};
    vecs[3]  = '{16'h3C01, 16'h3E00, 16'h3E02};
    vecs[4]  = '{16'h3C03, 16'h3E00, 16'h3E04};
    vecs[5]  = '{16'h7BFF, 16'h4000, 16'h7C00};
    vecs[6]  = '{16'h7C00, 16'h0000, 16'h7E00};
    vecs[7]  = '{16'hFC00, 16'h4000, 16'hFC00};
    vecs[8]  = '{16'h8000, 16'h3C00, 16'h8000};
    vecs[9]  = '{16'h7C01, 16'h3C00, 16'h7E00};
    vecs[10] = '{16'h7C00, 16'hFC00, 16'hFC00};
    vecs[13] = '{16'hC000, 16'hC000, 16'h4400};
`ifdef FPMUL_SUBNORMAL_EN
    vecs[11] = '{16'h0400, 16'h3800, 16'h0200};
    vecs[12] = '{16'h0001, 16'h6400, 16'h0400};
    vecs[14] = '{16'h0001, 16'h3C00, 16'h0001};
    vecs[15] = '{16'h8001, 16'h3C00, 16'h8001};
`else
    vecs[11] = '{16'h0400, 16'h3800, 16'h0000};
    vecs[12] = '{16'h0001, 16'h6400, 16'h0000};
    vecs[14] = '{16'h0001, 16'h3C00, 16'h0000};
    vecs[15] = '{16'h8001, 16'h3C00, 16'h8000};
`endif

    reset = 1'b1;
    en    = 1'b0;
    a     = 16'h0;
    b     = 16'h0;
    repeat (2) @(negedge clk);
    check("reset_state", result, 16'h0000);
    reset = 1'b0;

    // Load a product, then assert reset between edges.
    a = 16'h4200; b = 16'hC600; en = 1'b1;
    @(negedge clk);
    check("mul_3x-6", result, 16'hCC80);
    #2 reset = 1'b1;
    #1 check("async_reset", result, 16'h0000);
    @(negedge clk);
    check("reset_hold", result, 16'h0000);
    reset = 1'b0;

    // Enable gating.
    a = 16'h4000; b = 16'h4000; en = 1'b1;
    @(negedge clk);
    check("en_load", result, 16'h4400);
    a = 16'h3C00; b = 16'h3C00; en = 1'b0;
    @(negedge clk);
    check("en_hold_1", result, 16'h4400);
    @(negedge clk);
    check("en_hold_2", result, 16'h4400);

    // Table applied back-to-back, one product per cycle.
    en = 1'b1;
    for (int i = 0; i <= NV; i++) begin
      if (i > 0) check($sformatf("vec%0d", i - 1), result, vecs[i-1].exp);
      if (i < NV) begin
        a = vecs[i].a;
        b = vecs[i].b;
        @(negedge clk);
      end
    end
    en = 1'b0;

    // Reset pulse between operand capture and readback.
    @(negedge clk);
    a = 16'h4200; b = 16'h4200; en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_midop", result, 16'h0000);
    en = 1'b1;
    @(negedge clk);
    check("post_reset", result, 16'h4880);
    en = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
